i2c_multi_ram_ctrl: RTL and testbench
=====================================

I2C_MULTI_RAM_CTRL -- requirements
Module: i2c_multi_ram_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width of remote and local RAM.
REQ-002 SHALL have parameter ADDR_W, default 5 (minimum 4), RAM address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter CLEAR_CHAR, default 8'h20, fill word written by the clear sequencer.
REQ-004 SHALL have clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 SHALL have menu_sel, input, 4: menu ROM row, 0-12.
REQ-007 SHALL have ram_sel, input, 2: 0 = menu ROM, 1 = remote RAM, 2 = local RAM, 3 = reserved.
REQ-008 SHALL have mr_addr, input, ADDR_W: menu-controller address.
REQ-009 SHALL have mr_din, input, DATA_W: menu-controller write data.
REQ-010 SHALL have mr_we, input, 1: menu-controller write strobe, local RAM only.
REQ-011 SHALL have mr_dout, output, DATA_W: menu-controller read data.
REQ-012 SHALL have clr_req, input, 1: start a clear of the bank selected by ram_sel.
REQ-013 SHALL have clr_busy, output, 1: clear sequence in progress.
REQ-014 SHALL have clr_done, output, 1: one-cycle pulse after the final clear write.
REQ-015 SHALL have rem_we / rem_waddr / rem_din, inputs, 1 / ADDR_W / DATA_W: I2C-master write port into remote RAM.
REQ-016 SHALL have slv_we / slv_waddr / slv_din, inputs, 1 / ADDR_W / DATA_W: I2C-slave write port into local RAM.
REQ-017 SHALL have slv_raddr, input, ADDR_W: I2C-slave read address into local RAM.
REQ-018 SHALL have slv_dout, output, DATA_W: I2C-slave read data.
REQ-019 SHALL have wr_drop, output, 1: one-cycle pulse when any write is discarded.

Function
REQ-020 mr_dout SHALL be registered with 1-cycle latency from {ram_sel, mr_addr, menu_sel}. Menu reads use mr_addr[3:0] and the 13x16 menu ROM (unused cells 8'hFE). ram_sel=3 or menu_sel>12 SHALL give 0.
REQ-021 slv_dout SHALL be registered with 1-cycle latency. A read of an address written in the same cycle SHALL return the old data.
REQ-022 FSM states SHALL be IDLE and CLEAR. Transition IDLE->CLEAR occurs on clr_req with ram_sel in {1,2}, latching the target bank and setting cnt=0. clr_req with ram_sel in {0,3} SHALL be ignored.
REQ-023 In CLEAR, each cycle SHALL write CLEAR_CHAR to target[cnt] and increment cnt. After the write at cnt=DEPTH-1 the FSM SHALL return to IDLE and pulse clr_done in the following cycle. Clear duration SHALL be exactly DEPTH cycles.
REQ-024 clr_busy SHALL be 1 exactly while in CLEAR. clr_req while busy SHALL be ignored.
REQ-025 Local RAM write priority SHALL be clear > mr_we > slv_we. The losing write SHALL be discarded and SHALL pulse wr_drop the next cycle.
REQ-026 Remote RAM write priority SHALL be clear > rem_we. A rem_we to remote RAM during a remote clear SHALL be discarded and SHALL pulse wr_drop.
REQ-027 Writes to the bank not being cleared SHALL proceed normally during CLEAR.
REQ-028 Reads during CLEAR SHALL return the current array contents (read-before-write).

Reset
REQ-029 On rst: FSM=IDLE, cnt=0, mr_dout=0, slv_dout=0, clr_busy=0, clr_done=0, wr_drop=0.
REQ-030 RAM contents SHALL NOT be altered by rst. rst mid-clear SHALL abort the clear with no clr_done, leaving words already cleared as CLEAR_CHAR.
REQ-031 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-032 The shared package SHALL hold the ram_sel encodings, menu row indices 0-12, the character constants and the FSM state enumeration.
REQ-033 The menu ROM SHALL be a sub-module i2c_menu_rom (row, column in; registered byte out).

Verification
REQ-034 Write mr_we addr 5 = 8'hA5, then read ram_sel=2 addr 5 -> mr_dout=8'hA5 one cycle later; slv_raddr=5 -> slv_dout=8'hA5.
REQ-035 mr_we and slv_we in the same cycle to addr 3 (8'h11 / 8'h22) -> local[3]=8'h11, wr_drop pulses once.
REQ-036 clr_req with ram_sel=2 -> clr_busy high 32 cycles, clr_done pulse at cycle 33, all local words 8'h20, remote RAM untouched.
REQ-037 rem_we during a remote clear -> write lost, wr_drop=1; local slv_we in the same window succeeds.
REQ-038 rst at clear cycle 10 -> clr_busy=0, no clr_done, local[0..9]=8'h20, local[10..31] unchanged.
REQ-039 ram_sel=0, menu_sel=0, mr_addr 0..3 -> "MAIN" (8'h4D, 41, 49, 4E); menu_sel=13 -> 0.

Source files
------------

// File: rtl/i2c_multi_ram_ctrl_pkg.sv
// Shared constants for the I2C menu / RAM controller: bank selects,
// menu row indices, character codes and the clear FSM states.
package i2c_multi_ram_ctrl_pkg;

   localparam logic [1:0] SEL_MENU   = 2'd0;
   localparam logic [1:0] SEL_REMOTE = 2'd1;
   localparam logic [1:0] SEL_LOCAL  = 2'd2;
   localparam logic [1:0] SEL_RSVD   = 2'd3;

   localparam logic [3:0] MENU_MAIN    = 4'd0;
   localparam logic [3:0] MENU_REMOTE  = 4'd1;
   localparam logic [3:0] MENU_LOCAL   = 4'd2;
   localparam logic [3:0] MENU_CLEAR   = 4'd3;
   localparam logic [3:0] MENU_STATUS  = 4'd4;
   localparam logic [3:0] MENU_ADDRESS = 4'd5;
   localparam logic [3:0] MENU_SPEED   = 4'd6;
   localparam logic [3:0] MENU_MODE    = 4'd7;
   localparam logic [3:0] MENU_SETUP   = 4'd8;
   localparam logic [3:0] MENU_DIAG    = 4'd9;
   localparam logic [3:0] MENU_VERSION = 4'd10;
   localparam logic [3:0] MENU_HELP    = 4'd11;
   localparam logic [3:0] MENU_EXIT    = 4'd12;

   localparam logic [7:0] CHAR_SPACE  = 8'h20;
   localparam logic [7:0] CHAR_UNUSED = 8'hFE;
   localparam logic [7:0] CHAR_NONE   = 8'h00;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/i2c_multi_ram_ctrl_menu_rom.sv
// 13x16 menu text ROM. Each row holds a left-aligned label; cells past the
// label read 8'hFE, rows beyond the last label read 0. Output is registered.
module i2c_menu_rom
   import i2c_multi_ram_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic [3:0] row,
   input  logic [3:0] col,
   output logic [7:0] data_out
);

   logic [95:0] text;
   logic [3:0]  len;
   logic [3:0]  pos;
   logic [7:0]  data_d;
   logic [7:0]  data_q;

   // label lookup and character pick for the addressed cell
   always_comb begin
      text = '0;
      len  = 4'd0;
      case (row)
         MENU_MAIN:    begin text = 96'("MAIN");    len = 4'd4; end
         MENU_REMOTE:  begin text = 96'("REMOTE");  len = 4'd6; end
         MENU_LOCAL:   begin text = 96'("LOCAL");   len = 4'd5; end
         MENU_CLEAR:   begin text = 96'("CLEAR");   len = 4'd5; end
         MENU_STATUS:  begin text = 96'("STATUS");  len = 4'd6; end
         MENU_ADDRESS: begin text = 96'("ADDRESS"); len = 4'd7; end
         MENU_SPEED:   begin text = 96'("SPEED");   len = 4'd5; end
         MENU_MODE:    begin text = 96'("MODE");    len = 4'd4; end
         MENU_SETUP:   begin text = 96'("SETUP");   len = 4'd5; end
         MENU_DIAG:    begin text = 96'("DIAG");    len = 4'd4; end
         MENU_VERSION: begin text = 96'("VERSION"); len = 4'd7; end
         MENU_HELP:    begin text = 96'("HELP");    len = 4'd4; end
         MENU_EXIT:    begin text = 96'("EXIT");    len = 4'd4; end
         default:      begin text = '0;             len = 4'd0; end
      endcase
      // first character sits in the most significant occupied byte
      pos = len - 4'd1 - col;
      if (row > MENU_EXIT)
         data_d = CHAR_NONE;
      else if (col < len)
         data_d = 8'(text >> {pos, 3'b000});
      else
         data_d = CHAR_UNUSED;
   end

   // output register
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign data_out = data_q;

endmodule

// File: rtl/i2c_multi_ram_ctrl.sv
// Menu controller front end for the remote (I2C master) and local (I2C slave)
// RAM banks, with a clear sequencer that fills one bank with CLEAR_CHAR.
//
// state    | meaning
// ST_IDLE  | no clear running; clr_req on remote/local starts one
// ST_CLEAR | writing CLEAR_CHAR to target[cnt], one word per cycle
module i2c_multi_ram_ctrl
   import i2c_multi_ram_ctrl_pkg::*;
#(
   parameter int                DATA_W     = 8,
   parameter int                ADDR_W     = 5,
   parameter logic [DATA_W-1:0] CLEAR_CHAR = DATA_W'(CHAR_SPACE)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        menu_sel,
   input  logic [1:0]        ram_sel,
   input  logic [ADDR_W-1:0] mr_addr,
   input  logic [DATA_W-1:0] mr_din,
   input  logic              mr_we,
   output logic [DATA_W-1:0] mr_dout,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   input  logic              rem_we,
   input  logic [ADDR_W-1:0] rem_waddr,
   input  logic [DATA_W-1:0] rem_din,
   input  logic              slv_we,
   input  logic [ADDR_W-1:0] slv_waddr,
   input  logic [DATA_W-1:0] slv_din,
   input  logic [ADDR_W-1:0] slv_raddr,
   output logic [DATA_W-1:0] slv_dout,
   output logic              wr_drop
);

   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              tgt_local_q, tgt_local_d;
   logic              clr_done_q, clr_done_d;
   logic              wr_drop_q, wr_drop_d;
   logic              rom_sel_q, rom_sel_d;
   logic [DATA_W-1:0] mr_ram_q, mr_ram_d;
   logic [DATA_W-1:0] slv_dout_q, slv_dout_d;

   logic [DATA_W-1:0] rem_mem_q [DEPTH];
   logic [DATA_W-1:0] loc_mem_q [DEPTH];

   logic              clr_loc, clr_rem;
   logic              loc_we;
   logic [ADDR_W-1:0] loc_waddr;
   logic [DATA_W-1:0] loc_wdata;
   logic              rem_we_eff;
   logic [ADDR_W-1:0] rem_waddr_eff;
   logic [DATA_W-1:0] rem_wdata;
   logic [7:0]        rom_data;

   i2c_menu_rom u_menu_rom (
      .clk      (clk),
      .row      (menu_sel),
      .col      (mr_addr[3:0]),
      .data_out (rom_data)
   );

   // FSM state register and control flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         tgt_local_q <= 1'b0;
         clr_done_q  <= 1'b0;
         wr_drop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tgt_local_q <= tgt_local_d;
         clr_done_q  <= clr_done_d;
         wr_drop_q   <= wr_drop_d;
      end
   end

   // next state: start a clear on a RAM bank, finish after the last word
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tgt_local_d = tgt_local_q;
      clr_done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clr_req && (ram_sel == SEL_REMOTE || ram_sel == SEL_LOCAL)) begin
               state_d     = ST_CLEAR;
               cnt_d       = '0;
               tgt_local_d = (ram_sel == SEL_LOCAL);
            end
         end
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d    = ST_IDLE;
               clr_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      clr_busy = (state_q == ST_CLEAR);
      clr_loc  = clr_busy && tgt_local_q;
      clr_rem  = clr_busy && !tgt_local_q;
      clr_done = clr_done_q;
   end

   // write arbitration: clear beats menu writes, menu beats slave writes
   always_comb begin
      loc_we        = clr_loc || mr_we || slv_we;
      loc_waddr     = clr_loc ? cnt_q : (mr_we ? mr_addr : slv_waddr);
      loc_wdata     = clr_loc ? CLEAR_CHAR : (mr_we ? mr_din : slv_din);
      rem_we_eff    = clr_rem || rem_we;
      rem_waddr_eff = clr_rem ? cnt_q : rem_waddr;
      rem_wdata     = clr_rem ? CLEAR_CHAR : rem_din;
      wr_drop_d     = (clr_loc && (mr_we || slv_we)) ||
                      (!clr_loc && mr_we && slv_we) ||
                      (clr_rem && rem_we);
   end

   // RAM arrays: never reset, but writes are blocked while rst is high
   always_ff @(posedge clk) begin
      if (!rst && loc_we)
         loc_mem_q[loc_waddr] <= loc_wdata;
      if (!rst && rem_we_eff)
         rem_mem_q[rem_waddr_eff] <= rem_wdata;
   end

   // read ports see the array before this cycle's write
   always_comb begin
      rom_sel_d  = (ram_sel == SEL_MENU);
      slv_dout_d = loc_mem_q[slv_raddr];
      case (ram_sel)
         SEL_REMOTE: mr_ram_d = rem_mem_q[mr_addr];
         SEL_LOCAL:  mr_ram_d = loc_mem_q[mr_addr];
         default:    mr_ram_d = '0;
      endcase
   end

   // read data registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rom_sel_q  <= 1'b0;
         mr_ram_q   <= '0;
         slv_dout_q <= '0;
      end else begin
         rom_sel_q  <= rom_sel_d;
         mr_ram_q   <= mr_ram_d;
         slv_dout_q <= slv_dout_d;
      end
   end

   assign mr_dout  = rom_sel_q ? DATA_W'(rom_data) : mr_ram_q;
   assign slv_dout = slv_dout_q;
   assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_i2c_multi_ram_ctrl.sv
module tb_i2c_multi_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] menu_sel;
   logic [1:0] ram_sel;
   logic [4:0] mr_addr;
   logic [7:0] mr_din;
   logic       mr_we;
   logic [7:0] mr_dout;
   logic       clr_req;
   logic       clr_busy;
   logic       clr_done;
   logic       rem_we;
   logic [4:0] rem_waddr;
   logic [7:0] rem_din;
   logic       slv_we;
   logic [4:0] slv_waddr;
   logic [7:0] slv_din;
   logic [4:0] slv_raddr;
   logic [7:0] slv_dout;
   logic       wr_drop;

   i2c_multi_ram_ctrl dut (
      .clk(clk), .rst(rst), .menu_sel(menu_sel), .ram_sel(ram_sel),
      .mr_addr(mr_addr), .mr_din(mr_din), .mr_we(mr_we), .mr_dout(mr_dout),
      .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
      .rem_we(rem_we), .rem_waddr(rem_waddr), .rem_din(rem_din),
      .slv_we(slv_we), .slv_waddr(slv_waddr), .slv_din(slv_din),
      .slv_raddr(slv_raddr), .slv_dout(slv_dout), .wr_drop(wr_drop)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   string      names [13] = '{"MAIN", "REMOTE", "LOCAL", "CLEAR", "STATUS", "ADDRESS",
                              "SPEED", "MODE", "SETUP", "DIAG", "VERSION", "HELP", "EXIT"};
   logic [7:0] rem_m [32];
   logic [7:0] loc_m [32];
   bit         clearing = 0;
   bit         clr_local = 0;
   int         clr_idx = 0;
   logic [7:0] e_mr, e_slv;
   logic       e_busy, e_done, e_drop;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] menu;
      logic [4:0] addr;
      logic       mwe;
      logic [7:0] mdin;
      logic       swe;
      logic [4:0] swaddr;
      logic [7:0] sdin;
      logic       rwe;
      logic [4:0] rwaddr;
      logic [7:0] rdin;
      logic [7:0] exp_mr;
      logic [7:0] exp_slv;
      logic       exp_drop;
   } vec_t;

   vec_t vecs [15];

   function automatic logic [7:0] rom_char(int row, int col);
      if (row > 12) return 8'h00;
      if (col < names[row].len()) return names[row][col];
      return 8'hFE;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      if ($isunknown(exp)) return;
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [7:0] nm, ns;
      logic       nd, nn;
      if (rst) begin
         e_mr = 8'h00; e_slv = 8'h00; e_busy = 1'b0; e_done = 1'b0; e_drop = 1'b0;
         clearing = 0; clr_idx = 0;
         return;
      end
      case (ram_sel)
         2'd0:    nm = rom_char(int'(menu_sel), int'(mr_addr[3:0]));
         2'd1:    nm = rem_m[mr_addr];
         2'd2:    nm = loc_m[mr_addr];
         default: nm = 8'h00;
      endcase
      ns = loc_m[slv_raddr];
      nd = 1'b0;
      nn = 1'b0;
      if (clearing && clr_local) begin
         loc_m[clr_idx] = 8'h20;
         if (mr_we || slv_we) nd = 1'b1;
      end else if (mr_we) begin
         loc_m[mr_addr] = mr_din;
         if (slv_we) nd = 1'b1;
      end else if (slv_we) begin
         loc_m[slv_waddr] = slv_din;
      end
      if (clearing && !clr_local) begin
         rem_m[clr_idx] = 8'h20;
         if (rem_we) nd = 1'b1;
      end else if (rem_we) begin
         rem_m[rem_waddr] = rem_din;
      end
      if (clearing) begin
         clr_idx++;
         if (clr_idx == 32) begin
            clearing = 0;
            nn = 1'b1;
         end
      end else if (clr_req && (ram_sel == 2'd1 || ram_sel == 2'd2)) begin
         clearing  = 1;
         clr_idx   = 0;
         clr_local = (ram_sel == 2'd2);
      end
      e_mr = nm; e_slv = ns; e_drop = nd; e_done = nn; e_busy = clearing;
   endtask

   // one clock: model consumes current inputs, DUT outputs compared after the edge
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      chk("mr_dout", mr_dout, e_mr);
      chk("slv_dout", slv_dout, e_slv);
      chk("clr_busy", {7'd0, clr_busy}, {7'd0, e_busy});
      chk("clr_done", {7'd0, clr_done}, {7'd0, e_done});
      chk("wr_drop", {7'd0, wr_drop}, {7'd0, e_drop});
   endtask

   task automatic set_idle();
      rst = 0; menu_sel = 0; ram_sel = 0; mr_addr = 0; mr_din = 0; mr_we = 0;
      clr_req = 0; rem_we = 0; rem_waddr = 0; rem_din = 0;
      slv_we = 0; slv_waddr = 0; slv_din = 0; slv_raddr = 0;
   endtask

   task automatic wait_clear_end(input string name);
      int n;
      n = 0;
      while (clr_busy && n < 40) begin
         step();
         n++;
      end
      if (clr_busy) begin
         errors++;
         $display("FAIL %s: clr_busy still 1 after %0d cycles, required 0", name, n);
      end
   endtask

   initial begin
      int busy_cnt, done_at, done_cnt;
      for (int i = 0; i < 32; i++) begin
         rem_m[i] = 'x;
         loc_m[i] = 'x;
      end
      set_idle();

      // reset
      rst = 1;
      step();
      step();
      chk("rst_mr_dout", mr_dout, 8'h00);
      chk("rst_busy", {7'd0, clr_busy}, 8'h00);
      set_idle();
      step();

      // clear remote bank so both banks hold known data
      ram_sel = 2'd1; clr_req = 1;
      step();
      set_idle();
      wait_clear_end("init_remote_clear");
      step();
      rem_we = 1; rem_waddr = 5'd9; rem_din = 8'h3C;
      step();
      set_idle();

      // local clear: busy length and done timing
      ram_sel = 2'd2; clr_req = 1;
      step();
      set_idle();
      busy_cnt = clr_busy ? 1 : 0;
      done_at  = 0;
      for (int k = 2; k <= 40; k++) begin
         step();
         if (clr_busy) busy_cnt++;
         if (clr_done && done_at == 0) done_at = k;
      end
      chk("clear_busy_len", 8'(busy_cnt), 8'd32);
      chk("clear_done_cycle", 8'(done_at), 8'd33);
      for (int i = 0; i < 32; i++) begin
         slv_raddr = 5'(i);
         step();
         chk("local_cleared", slv_dout, 8'h20);
      end
      ram_sel = 2'd1; mr_addr = 5'd9;
      step();
      chk("remote_untouched", mr_dout, 8'h3C);
      set_idle();

      // directed vectors (local and remote all 8'h20 except remote[9])
      vecs[0]  = '{2'd2, 4'd0,  5'd5,  1, 8'hA5, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'h20, 8'h20, 0};
      vecs[1]  = '{2'd2, 4'd0,  5'd5,  0, 8'h00, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'hA5, 8'hA5, 0};
      vecs[2]  = '{2'd2, 4'd0,  5'd3,  1, 8'h11, 1, 5'd3, 8'h22, 0, 5'd0, 8'h00, 8'h20, 8'h20, 1};
      vecs[3]  = '{2'd2, 4'd0,  5'd3,  0, 8'h00, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'h11, 8'h11, 0};
      vecs[4]  = '{2'd0, 4'd0,  5'd0,  0, 8'h00, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'h4D, 8'h20, 0};
      vecs[5]  = '{2'd0, 4'd0,  5'd1,  0, 8'h00, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'h41, 8'h20, 0};
      vecs[6]  = '{2'd0, 4'd0,  5'd2,  0, 8'h00, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'h49, 8'h20, 0};
      vecs[7]  = '{2'd0, 4'd0,  5'd3,  0, 8'h00, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'h4E, 8'h11, 0};
      vecs[8]  = '{2'd0, 4'd13, 5'd0,  0, 8'h00, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'h00, 8'h20, 0};
      vecs[9]  = '{2'd3, 4'd0,  5'd5,  0, 8'h00, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'h00, 8'hA5, 0};
      vecs[10] = '{2'd1, 4'd0,  5'd5,  0, 8'h00, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'h20, 8'hA5, 0};
      vecs[11] = '{2'd0, 4'd0,  5'd15, 0, 8'h00, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'hFE, 8'h20, 0};
      vecs[12] = '{2'd1, 4'd0,  5'd7,  0, 8'h00, 0, 5'd0, 8'h00, 1, 5'd7, 8'h5A, 8'h20, 8'h20, 0};
      vecs[13] = '{2'd1, 4'd0,  5'd7,  0, 8'h00, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'h5A, 8'h20, 0};
      vecs[14] = '{2'd0, 4'd1,  5'd2,  0, 8'h00, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'h4D, 8'h20, 0};
      foreach (vecs[i]) begin
         ram_sel = vecs[i].sel; menu_sel = vecs[i].menu; mr_addr = vecs[i].addr;
         slv_raddr = vecs[i].addr;
         mr_we = vecs[i].mwe; mr_din = vecs[i].mdin;
         slv_we = vecs[i].swe; slv_waddr = vecs[i].swaddr; slv_din = vecs[i].sdin;
         rem_we = vecs[i].rwe; rem_waddr = vecs[i].rwaddr; rem_din = vecs[i].rdin;
         step();
         chk("vec_mr_dout", mr_dout, vecs[i].exp_mr);
         chk("vec_slv_dout", slv_dout, vecs[i].exp_slv);
         chk("vec_wr_drop", {7'd0, wr_drop}, {7'd0, vecs[i].exp_drop});
      end
      set_idle();

      // rem_we lost during a remote clear, slave write to local still lands
      ram_sel = 2'd1; clr_req = 1;
      step();
      set_idle();
      step();
      step();
      step();
      rem_we = 1; rem_waddr = 5'd2; rem_din = 8'h77;
      slv_we = 1; slv_waddr = 5'd4; slv_din = 8'h66;
      step();
      chk("rem_drop_pulse", {7'd0, wr_drop}, 8'h01);
      set_idle();
      wait_clear_end("remote_clear");
      ram_sel = 2'd1; mr_addr = 5'd2; slv_raddr = 5'd4;
      step();
      chk("rem_write_lost", mr_dout, 8'h20);
      chk("slv_write_kept", slv_dout, 8'h66);
      set_idle();

      // reset in the middle of a local clear
      for (int i = 0; i < 32; i++) begin
         mr_we = 1; mr_addr = 5'(i); mr_din = 8'(i) ^ 8'hC3;
         step();
      end
      set_idle();
      ram_sel = 2'd2; clr_req = 1;
      step();
      set_idle();
      for (int k = 0; k < 10; k++) step();
      rst = 1;
      step();
      chk("abort_busy", {7'd0, clr_busy}, 8'h00);
      set_idle();
      done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (clr_done) done_cnt++;
      end
      chk("abort_no_done", 8'(done_cnt), 8'd0);
      for (int i = 0; i < 32; i++) begin
         slv_raddr = 5'(i);
         step();
         chk("abort_contents", slv_dout, (i < 10) ? 8'h20 : (8'(i) ^ 8'hC3));
      end
      set_idle();

      // randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         rst       = ($urandom_range(0, 199) == 0);
         ram_sel   = 2'($urandom_range(0, 3));
         menu_sel  = 4'($urandom_range(0, 15));
         mr_addr   = 5'($urandom);
         mr_din    = 8'($urandom);
         mr_we     = ($urandom_range(0, 2) == 0);
         clr_req   = ($urandom_range(0, 24) == 0);
         rem_we    = ($urandom_range(0, 2) == 0);
         rem_waddr = 5'($urandom);
         rem_din   = 8'($urandom);
         slv_we    = ($urandom_range(0, 2) == 0);
         slv_waddr = 5'($urandom);
         slv_din   = 8'($urandom);
         slv_raddr = 5'($urandom);
         step();
      end
      set_idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
